fb_write_ctrl: RTL and testbench

- Write-port controller for the 40x30 VGA framebuffer RAM (2048 x 8, address = {row[4:0], col[5:0]}).
- Owns the RAM's shared write/read port (WA1/WD/WE/RD1) and arbitrates it between two sources:
  - MCU single-pixel writes and readback;
  - a hardware rectangle-fill engine that paints a clipped W x H block one pixel per cycle.
- The RAM's second read port (RA2/RD2) stays with the VGA scan driver and is untouched.

---
 rtl/fb_write_ctrl.sv | 145 ++++++++++++++
 tb/tb_fb_write_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: framebuffer write-port arbiter between MCU pixel access and a rectangle-fill engine
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   MCU_WE/ADDR/WD      MCU single-pixel write (fixed priority over the fill engine)
//   MCU_RD              readback from RAM RD1, valid while MCU_BUSY = 0
//   MCU_BUSY            high while the fill engine owns the port (state != IDLE)
//   FILL_START          fill request, sampled only in IDLE
//   FILL_X0/Y0/W/H      rectangle origin and size, clipped against COLS x ROWS
//   FILL_COLOR          fill color
//   FILL_BUSY           high in FILL and DONE
//   FILL_DONE           one-cycle completion pulse
//   RAM_WA/WD/WE        shared RAM write port, address = {row, col}
//   RAM_RD1             RAM read data for the shared port
module fb_write_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MCU_WE,
    input  logic [10:0] MCU_ADDR,
    input  logic [7:0]  MCU_WD,
    output logic [7:0]  MCU_RD,
    output logic        MCU_BUSY,
    input  logic        FILL_START,
    input  logic [5:0]  FILL_X0,
    input  logic [4:0]  FILL_Y0,
    input  logic [5:0]  FILL_W,
    input  logic [4:0]  FILL_H,
    input  logic [7:0]  FILL_COLOR,
    output logic        FILL_BUSY,
    output logic        FILL_DONE,
    output logic [10:0] RAM_WA,
    output logic [7:0]  RAM_WD,
    output logic        RAM_WE,
    input  logic [7:0]  RAM_RD1
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t     state_q, state_d;
    logic [5:0] x_q, x_d, x0_q, x0_d, xl_q, xl_d;
    logic [4:0] y_q, y_d, yl_q, yl_d;
    logic [7:0] color_q, color_d;
    logic       hold_q, hold_d, busy_q, busy_d, done_q, done_d;
    logic [6:0] cols_left, rows_left, wc, hc;
    logic [5:0] x_end;
    logic [4:0] y_end;
    logic       fill_wr;

    // Clipped extents in 7-bit arithmetic; last column/row are kept so the
    // engine only needs equality compares while painting.
    always_comb begin
        cols_left = 7'(COLS) - {1'b0, FILL_X0};
        rows_left = 7'(ROWS) - {2'b0, FILL_Y0};
        wc = ({1'b0, FILL_X0} >= 7'(COLS)) ? 7'd0 :
             (({1'b0, FILL_W} < cols_left) ? {1'b0, FILL_W} : cols_left);
        hc = ({2'b0, FILL_Y0} >= 7'(ROWS)) ? 7'd0 :
             (({2'b0, FILL_H} < rows_left) ? {2'b0, FILL_H} : rows_left);
        x_end = FILL_X0 + wc[5:0] - 6'd1;
        y_end = FILL_Y0 + hc[4:0] - 5'd1;
    end

    // A zero-area fill spends two cycles in DONE (hold_q set on entry) so its
    // pulse lands one cycle after the start, like a single-pixel fill.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        color_d = color_q;
        hold_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (FILL_START) begin
                    x0_d    = FILL_X0;
                    x_d     = FILL_X0;
                    y_d     = FILL_Y0;
                    xl_d    = x_end;
                    yl_d    = y_end;
                    color_d = FILL_COLOR;
                    if (wc != 7'd0 && hc != 7'd0) begin
                        state_d = FILL;
                    end else begin
                        state_d = DONE;
                        hold_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                // An MCU write steals the port; the engine holds its position.
                if (!MCU_WE) begin
                    if (x_q == xl_q) begin
                        x_d = x0_q;
                        if (y_q == yl_q) state_d = DONE;
                        else             y_d = y_q + 5'd1;
                    end else begin
                        x_d = x_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = hold_q ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE && !hold_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
            color_q <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            color_q <= color_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fill_wr   = state_q == FILL && !MCU_WE;
    assign RAM_WA    = fill_wr ? {y_q, x_q} : MCU_ADDR;
    assign RAM_WD    = fill_wr ? color_q : MCU_WD;
    assign RAM_WE    = !RST && (fill_wr || MCU_WE);
    assign MCU_RD    = RAM_RD1;
    assign MCU_BUSY  = busy_q;
    assign FILL_BUSY = busy_q;
    assign FILL_DONE = done_q;
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: scoreboard bench for fb_write_ctrl with a behavioural framebuffer RAM
module tb_fb_write_ctrl;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        MCU_WE = 1'b0, FILL_START = 1'b0;
    logic [10:0] MCU_ADDR = '0;
    logic [7:0]  MCU_WD = '0, FILL_COLOR = '0;
    logic [5:0]  FILL_X0 = '0, FILL_W = '0;
    logic [4:0]  FILL_Y0 = '0, FILL_H = '0;
    logic [7:0]  MCU_RD, RAM_WD, RAM_RD1;
    logic        MCU_BUSY, FILL_BUSY, FILL_DONE, RAM_WE;
    logic [10:0] RAM_WA;

    fb_write_ctrl dut (
        .CLK(CLK), .RST(RST),
        .MCU_WE(MCU_WE), .MCU_ADDR(MCU_ADDR), .MCU_WD(MCU_WD), .MCU_RD(MCU_RD), .MCU_BUSY(MCU_BUSY),
        .FILL_START(FILL_START), .FILL_X0(FILL_X0), .FILL_Y0(FILL_Y0), .FILL_W(FILL_W), .FILL_H(FILL_H),
        .FILL_COLOR(FILL_COLOR), .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
        .RAM_WA(RAM_WA), .RAM_WD(RAM_WD), .RAM_WE(RAM_WE), .RAM_RD1(RAM_RD1)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [2048];
    initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    always @(posedge CLK) if (RAM_WE) mem[RAM_WA] <= RAM_WD;
    assign RAM_RD1 = mem[RAM_WA];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [10:0] a; logic [7:0] d; int n; } wr_t;
    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0, errors = 0;

    // Monitor: every write seen on the port commits at the coming edge cyc+1.
    always @(negedge CLK) begin
        if (RAM_WE === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr %0d data %0h at edge %0d, required none", RAM_WA, RAM_WD, cyc + 1);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                if (RAM_WA !== w.a || RAM_WD !== w.d || cyc + 1 != w.n) begin
                    errors++;
                    $display("FAIL wr: got addr %0d data %0h edge %0d, required addr %0d data %0h edge %0d",
                             RAM_WA, RAM_WD, cyc + 1, w.a, w.d, w.n);
                end
            end
        end
        if (FILL_DONE === 1'b1) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got FILL_DONE after edge %0d, required none", cyc);
            end else begin
                int n;
                n = exp_done.pop_front();
                if (cyc != n) begin
                    errors++;
                    $display("FAIL done: got pulse after edge %0d, required after edge %0d", cyc, n);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issues a fill, pushes the expected writes/pulse, optionally stalls the
    // engine with an MCU write just before pixel `stall`, and optionally fires
    // stray FILL_STARTs while busy.
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input logic [7:0] color, input int stall, input bit junk);
        int wc, hc, n, e0;
        bit idle_seen;
        wc = (x0 >= 40) ? 0 : ((w < 40 - x0) ? w : 40 - x0);
        hc = (y0 >= 30) ? 0 : ((h < 30 - y0) ? h : 30 - y0);
        n  = wc * hc;
        e0 = cyc + 1;
        for (int i = 0; i < n; i++) begin
            if (stall == i) exp_wr.push_back('{11'd5, 8'hF9, e0 + 1 + i});
            exp_wr.push_back('{11'((y0 + i / wc) * 64 + x0 + i % wc), color,
                               e0 + 1 + i + ((stall >= 0 && i >= stall) ? 1 : 0)});
        end
        exp_done.push_back(e0 + ((n == 0) ? 1 : n) + ((stall >= 0 && n > 0) ? 1 : 0));
        FILL_X0 = 6'(x0); FILL_Y0 = 5'(y0); FILL_W = 6'(w); FILL_H = 5'(h); FILL_COLOR = color;
        FILL_START = 1'b1;
        step();
        idle_seen = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            MCU_WE = stall >= 0 && t == stall + 1;
            MCU_ADDR = 11'd5;
            MCU_WD = 8'hF9;
            FILL_START = junk && (t == 2 || FILL_DONE);
            FILL_X0 = 6'd10; FILL_Y0 = 5'd10; FILL_W = 6'd2; FILL_H = 5'd2; FILL_COLOR = 8'hEE;
            if (!FILL_BUSY) begin
                idle_seen = 1'b1;
                MCU_WE = 1'b0;
                FILL_START = 1'b0;
                break;
            end
            step();
        end
        chk("fill_terminates", 32'(idle_seen), 32'd1);
    endtask

    initial begin
        MCU_WE = 1'b1; MCU_ADDR = 11'd7; MCU_WD = 8'hAA;
        step();
        step();
        chk("rst_ram_we", 32'(RAM_WE), 32'd0);
        chk("rst_fill_busy", 32'(FILL_BUSY), 32'd0);
        chk("rst_fill_done", 32'(FILL_DONE), 32'd0);
        chk("rst_mcu_busy", 32'(MCU_BUSY), 32'd0);
        RST = 1'b0; MCU_WE = 1'b0;
        step();

        // MCU write and readback in IDLE
        exp_wr.push_back('{11'd600, 8'h4A, cyc + 1});
        MCU_WE = 1'b1; MCU_ADDR = 11'd600; MCU_WD = 8'h4A;
        step();
        MCU_WE = 1'b0;
        #1;
        chk("mcu_readback", 32'(MCU_RD), 32'h4A);
        chk("idle_fill_busy", 32'(FILL_BUSY), 32'd0);

        // Basic fill
        run_fill(2, 1, 3, 2, 8'h4A, -1, 1'b0);
        chk("basic_px66", 32'(mem[66]), 32'h4A);
        chk("basic_px132", 32'(mem[132]), 32'h4A);
        chk("basic_px69", 32'(mem[69]), 32'h00);

        // Clipping and zero-area
        run_fill(38, 29, 5, 3, 8'h10, -1, 1'b0);
        chk("clip_px1895", 32'(mem[1895]), 32'h10);
        chk("clip_px1896", 32'(mem[1896]), 32'h00);
        run_fill(40, 0, 4, 1, 8'h77, -1, 1'b0);

        // Collision with MCU write on the cycle the engine targets 67
        run_fill(2, 1, 3, 2, 8'h5C, 1, 1'b0);
        chk("coll_mcu5", 32'(mem[5]), 32'hF9);
        chk("coll_px67", 32'(mem[67]), 32'h5C);
        chk("coll_px131", 32'(mem[131]), 32'h5C);

        // Start while busy
        run_fill(2, 1, 3, 2, 8'h21, -1, 1'b1);
        chk("junk_px650", 32'(mem[650]), 32'h00);
        chk("junk_px68", 32'(mem[68]), 32'h21);
        step();

        // Reset after three of six writes
        begin
            int e0;
            e0 = cyc + 1;
            for (int i = 0; i < 3; i++) exp_wr.push_back('{11'(66 + i), 8'h33, e0 + 1 + i});
            FILL_X0 = 6'd2; FILL_Y0 = 5'd1; FILL_W = 6'd3; FILL_H = 5'd2; FILL_COLOR = 8'h33;
            FILL_START = 1'b1;
            step();
            FILL_START = 1'b0;
            step();
            step();
            step();
            RST = 1'b1; MCU_WE = 1'b1; MCU_ADDR = 11'd9;
            #1;
            chk("midrst_ram_we", 32'(RAM_WE), 32'd0);
            step();
            chk("midrst_fill_busy", 32'(FILL_BUSY), 32'd0);
            chk("midrst_fill_done", 32'(FILL_DONE), 32'd0);
            chk("midrst_mcu_busy", 32'(MCU_BUSY), 32'd0);
            chk("midrst_px130", 32'(mem[130]), 32'h21);
            RST = 1'b0; MCU_WE = 1'b0;
            step();
            step();
        end
        run_fill(2, 1, 3, 2, 8'h66, -1, 1'b0);
        chk("after_rst_px130", 32'(mem[130]), 32'h66);
        chk("after_rst_px132", 32'(mem[132]), 32'h66);

        step();
        step();
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
